register_file: RTL and testbench

General-purpose register file of the single-cycle CPU: 32 registers × 32 bits, two combinational read ports, one synchronous write port. Sits directly downstream of the 5-bit write-register selector, which picks rt or rd by RegDst; that selector's output drives WriteReg here. Read addresses come from instruction fields rs/rt. Read data feeds the ALU operand muxes and the memory store-data path.

---
 rtl/register_file.sv | 65 ++++++
 tb/tb_register_file.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: 32 x 32-bit general-purpose register file of the single-cycle CPU.
// Two combinational read ports (rs/rt) and one rising-edge write port. r0 reads as zero.
// BYPASS=1 forwards WriteData to a read port that addresses the register being written.
module register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned BYPASS     = 0
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  input  logic [ADDR_WIDTH-1:0] WriteReg,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  RegWrite,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  wr_en;

  // A write is effective only when enabled and not aimed at r0.
  always_comb begin
    wr_en = RegWrite && (WriteReg != '0);
  end

  // Storage: asynchronous clear, one write per rising edge; r0 is never written so stays zero.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[WriteReg] <= WriteData;
    end
  end

  // Read port 1: forced to zero in reset, optional write-through, otherwise stored value.
  always_comb begin
    ReadData1 = '0;
    if (ResetN) begin
      if ((BYPASS != 0) && wr_en && (ReadReg1 == WriteReg)) begin
        ReadData1 = WriteData;
      end else begin
        ReadData1 = mem_q[ReadReg1];
      end
    end
  end

  // Read port 2: same behaviour as port 1.
  always_comb begin
    ReadData2 = '0;
    if (ResetN) begin
      if ((BYPASS != 0) && wr_en && (ReadReg2 == WriteReg)) begin
        ReadData2 = WriteData;
      end else begin
        ReadData2 = mem_q[ReadReg2];
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file: both BYPASS settings run side by side on shared stimulus.
// Stimulus pushes expected read values into a queue; a negedge monitor pops and compares.
module tb_register_file;

  logic        Clock;
  logic        ResetN;
  logic [4:0]  ReadReg1, ReadReg2, WriteReg;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [31:0] rd1_b0, rd2_b0, rd1_b1, rd2_b1;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) dut_b0 (
    .Clock(Clock), .ResetN(ResetN), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReadData1(rd1_b0), .ReadData2(rd2_b0)
  );

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) dut_b1 (
    .Clock(Clock), .ResetN(ResetN), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReadData1(rd1_b1), .ReadData2(rd2_b1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model: plain array of register contents.
  logic [31:0] model [32];
  initial for (int i = 0; i < 32; i++) model[i] = '0;

  always @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (RegWrite && WriteReg != 5'd0) begin
      model[WriteReg] = WriteData;
    end
  end

  function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
    if (!ResetN) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (byp && RegWrite && WriteReg != 5'd0 && a == WriteReg) return WriteData;
    return model[a];
  endfunction

  typedef struct {
    string       nm;
    logic [31:0] e10, e20, e11, e21;
  } exp_t;

  exp_t q[$];
  bit   chk_valid;
  int   total, bad;

  task automatic push(input string nm);
    exp_t e;
    e.nm  = nm;
    e.e10 = exp_rd(1'b0, ReadReg1);
    e.e20 = exp_rd(1'b0, ReadReg2);
    e.e11 = exp_rd(1'b1, ReadReg1);
    e.e21 = exp_rd(1'b1, ReadReg2);
    q.push_back(e);
    chk_valid = 1'b1;
  endtask

  task automatic cmp(input string nm, input string port, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s %s: got=%08h want=%08h at %0t", nm, port, act, exp, $time);
    end
  endtask

  // Monitor: read outputs are sampled mid-cycle, away from the write edge.
  always @(negedge Clock) begin
    if (chk_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_underflow: got=empty want=entry at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        cmp(e.nm, "b0.rd1", rd1_b0, e.e10);
        cmp(e.nm, "b0.rd2", rd2_b0, e.e20);
        cmp(e.nm, "b1.rd1", rd1_b1, e.e11);
        cmp(e.nm, "b1.rd2", rd2_b1, e.e21);
      end
    end
  end

  task automatic cyc(input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                     input logic [4:0] r1, input logic [4:0] r2, input bit chk, input string nm);
    @(posedge Clock);
    #1;
    RegWrite  = rw;
    WriteReg  = wr;
    WriteData = wd;
    ReadReg1  = r1;
    ReadReg2  = r2;
    if (chk) push(nm);
    else chk_valid = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; chk_valid = 1'b0;
    ResetN = 1'b0; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    ReadReg1 = '0; ReadReg2 = '0;

    // Writes blocked and outputs zero while in reset.
    cyc(1'b1, 5'd4, 32'hFFFF0000, 5'd4, 5'd4, 1'b1, "in_reset");
    cyc(1'b1, 5'd6, 32'h0BADF00D, 5'd6, 5'd4, 1'b1, "in_reset2");
    @(posedge Clock); #1; RegWrite = 1'b0; chk_valid = 1'b0; #2 ResetN = 1'b1;
    cyc(1'b0, 5'd0, 32'h0, 5'd4, 5'd6, 1'b1, "after_init_reset");

    // Write/readback of every register with crossed read addresses.
    for (int k = 1; k < 32; k++)
      cyc(1'b1, 5'(k), 32'h1000_0000 + k, 5'(k), 5'(32 - k), 1'b1, "wr_all");
    for (int k = 1; k < 32; k++)
      cyc(1'b0, 5'd0, 32'h0, 5'(k), 5'(32 - k), 1'b1, "rd_all");

    // r0 protection, before and after the edge.
    cyc(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, "r0_write");
    cyc(1'b0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, "r0_after");

    // Write enable low keeps r7.
    cyc(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd0, 1'b0, "");
    for (int k = 0; k < 3; k++)
      cyc(1'b0, 5'd7, 32'h12345678, 5'd7, 5'd7, 1'b1, "we_low");
    cyc(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b1, "we_low_after");

    // Same-cycle read/write on r9.
    cyc(1'b1, 5'd9, 32'h11, 5'd0, 5'd0, 1'b0, "");
    cyc(1'b1, 5'd9, 32'h22, 5'd1, 5'd9, 1'b1, "r9_same_cycle");
    cyc(1'b0, 5'd9, 32'h33, 5'd9, 5'd9, 1'b1, "r9_after");

    // Back-to-back writes to r3, both ports on r3.
    cyc(1'b1, 5'd3, 32'h1, 5'd3, 5'd3, 1'b1, "b2b_r3");
    cyc(1'b1, 5'd3, 32'h2, 5'd3, 5'd3, 1'b1, "b2b_r3");
    cyc(1'b1, 5'd3, 32'h3, 5'd3, 5'd3, 1'b1, "b2b_r3");
    cyc(1'b0, 5'd3, 32'h4, 5'd3, 5'd3, 1'b1, "b2b_r3");

    // Asynchronous reset mid-cycle with a pending write, then release away from an edge.
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 1'b1, "pre_rst");
    @(posedge Clock); #1;
    RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hCAFE0001; ReadReg1 = 5'd5; ReadReg2 = 5'd3;
    chk_valid = 1'b0;
    #2 ResetN = 1'b0;
    #1 push("rst_async");
    cyc(1'b1, 5'd5, 32'hCAFE0002, 5'd5, 5'd9, 1'b1, "rst_hold");
    @(posedge Clock); #1; RegWrite = 1'b0; chk_valid = 1'b0;
    #2 ResetN = 1'b1;
    #1 push("rst_release");
    cyc(1'b0, 5'd0, 32'h0, 5'd5, 5'd3, 1'b1, "post_rst");

    // Randomized traffic, biased toward read/write address collisions and r0.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa, a1, a2;
      wa = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) wa = 5'd0;
      a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      cyc(1'($urandom_range(0, 3) != 0), wa, $urandom, a1, a2, 1'b1, "random");
    end

    // Drain the scoreboard within a bounded number of cycles.
    @(posedge Clock); #1; chk_valid = 1'b0;
    for (int w = 0; w < 4 && q.size() != 0; w++) @(negedge Clock);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got=%0d pending want=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
